// File: rtl/hsi_tx_sched_pkg.sv
// Shared constants and FSM state type for the HSI transmit scheduler and its generators.
package hsi_sched_pkg;

    localparam int GRANT_IDX_W = 3;
    localparam int DEF_DP_LEN  = 64;
    localparam int DEF_GAP_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/hsi_tx_sched_if.sv
// Bundle of source handshakes, link byte path and status for hsi_tx_sched.
interface hsi_tx_sched_if
    import hsi_sched_pkg::*;
#(
    parameter int N_SRC = 2
);
    logic [N_SRC-1:0]       src_tx_rdy;
    logic [N_SRC-1:0]       src_tx_en;
    logic [8*N_SRC-1:0]     src_d;
    logic [N_SRC-1:0]       src_d_rdy;
    logic [N_SRC-1:0]       src_d_ack;
    logic [7:0]             link_d;
    logic                   link_d_vld;
    logic                   link_rdy;
    logic                   link_sof;
    logic                   link_eof;
    logic [GRANT_IDX_W-1:0] grant_idx;
    logic                   busy;
    logic                   timeout_err;

    // Scheduler side
    modport master (
        input  src_tx_rdy, src_d, src_d_rdy, link_rdy,
        output src_tx_en, src_d_ack, link_d, link_d_vld, link_sof, link_eof,
               grant_idx, busy, timeout_err
    );

    // Sources and serializer side
    modport slave (
        output src_tx_rdy, src_d, src_d_rdy, link_rdy,
        input  src_tx_en, src_d_ack, link_d, link_d_vld, link_sof, link_eof,
               grant_idx, busy, timeout_err
    );
endinterface

// File: rtl/hsi_tx_sched_rr_arb.sv
// Combinational round-robin pick: first set request searching upward from ptr+1, wrapping.
module hsi_rr_arb
    import hsi_sched_pkg::*;
#(
    parameter int N_SRC = 2
)(
    input  logic [N_SRC-1:0]       i_req,
    input  logic [GRANT_IDX_W-1:0] i_ptr,
    output logic [GRANT_IDX_W-1:0] o_idx,
    output logic                   o_found
);
    int               w_cand;
    logic [N_SRC-1:0] w_shift;

    // Walk offsets from farthest to nearest so the nearest requester is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = 0;
        w_shift = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            w_cand  = (int'(i_ptr) + k) % N_SRC;
            w_shift = i_req >> w_cand;
            if (w_shift[0]) begin
                o_found = 1'b1;
                o_idx   = GRANT_IDX_W'(w_cand);
            end
        end
    end
endmodule

// File: rtl/hsi_tx_sched.sv
// Packet scheduler sharing one HSI byte link among N_SRC sources (round-robin per packet).
// Optional stall abort is enabled by defining HSI_SCHED_TIMEOUT_EN.
module hsi_tx_sched
    import hsi_sched_pkg::*;
#(
    parameter int N_SRC       = 2,
    parameter int DP_LEN      = DEF_DP_LEN,
    parameter int GAP_LEN     = DEF_GAP_LEN,
    parameter int TIMEOUT_CYC = 1024
)(
    input  logic           clk,
    input  logic           rst,
    hsi_tx_sched_if.master bus
);
    localparam int CNT_W = $clog2(DP_LEN + 1);
    localparam int GAP_W = $clog2(GAP_LEN + 1);

    if (N_SRC < 1 || N_SRC > 8) begin : g_bad_nsrc
        $error("hsi_tx_sched: N_SRC must be 1..8");
    end
    if (DP_LEN < 2 || (DP_LEN % 2) != 0) begin : g_bad_dplen
        $error("hsi_tx_sched: DP_LEN must be even and >= 2");
    end
    if (GAP_LEN < 1) begin : g_bad_gap
        $error("hsi_tx_sched: GAP_LEN must be >= 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("hsi_tx_sched: TIMEOUT_CYC must be >= 1");
    end

    sched_state_t           r_state;
    sched_state_t           w_state_nxt;
    logic [GRANT_IDX_W-1:0] r_ptr;
    logic [GRANT_IDX_W-1:0] r_grant;
    logic [CNT_W-1:0]       r_byte_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;

    logic [GRANT_IDX_W-1:0] w_arb_idx;
    logic                   w_arb_found;
    logic [N_SRC-1:0]       w_gnt_oh;
    logic [7:0]             w_sel_d;
    logic                   w_sel_rdy;
    logic                   w_in_xfer;
    logic                   w_xfer_raw;
    logic                   w_vld;
    logic                   w_xfer;
    logic                   w_last;
    logic                   w_gap_done;
    logic                   w_timeout;

    hsi_rr_arb #(.N_SRC(N_SRC)) u_arb (
        .i_req   (bus.src_tx_rdy),
        .i_ptr   (r_ptr),
        .o_idx   (w_arb_idx),
        .o_found (w_arb_found)
    );

    // Granted-source mux; r_grant is always below N_SRC once set by the arbiter.
    assign w_gnt_oh   = N_SRC'(1) << r_grant;
    assign w_sel_d    = 8'(bus.src_d >> {r_grant, 3'b000});
    assign w_sel_rdy  = |(bus.src_d_rdy & w_gnt_oh);

    assign w_in_xfer  = (r_state == ST_XFER);
    assign w_xfer_raw = w_sel_rdy & bus.link_rdy;
    assign w_vld      = w_in_xfer & w_sel_rdy & ~w_timeout;
    assign w_xfer     = w_vld & bus.link_rdy;
    assign w_last     = w_xfer & (r_byte_cnt == CNT_W'(DP_LEN - 1));
    assign w_gap_done = (r_gap_cnt == GAP_W'(GAP_LEN - 1));

`ifdef HSI_SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] r_stall;

    // The abort cycle is itself the TIMEOUT_CYC-th consecutive cycle without a transfer.
    assign w_timeout = w_in_xfer & ~w_xfer_raw & (r_stall == STALL_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (!w_in_xfer || w_xfer_raw) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|bus.src_tx_rdy) w_state_nxt = ST_ARB;
            ST_ARB:  w_state_nxt = w_arb_found ? ST_XFER : ST_IDLE;
            ST_XFER: if (w_last || w_timeout) w_state_nxt = ST_GAP;
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = (|bus.src_tx_rdy) ? ST_ARB : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= GRANT_IDX_W'(N_SRC - 1);
            r_grant    <= '0;
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ARB && w_arb_found) begin
                r_grant <= w_arb_idx;
                r_ptr   <= w_arb_idx;
            end
            if (!w_in_xfer || w_last || w_timeout) begin
                r_byte_cnt <= '0;
            end else if (w_xfer) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 1'b1 : '0;
        end
    end

    // Outputs are decoded from registered state so reset clears them on the next edge.
    assign bus.src_tx_en   = w_in_xfer ? w_gnt_oh : '0;
    assign bus.src_d_ack   = w_xfer ? w_gnt_oh : '0;
    assign bus.link_d      = w_in_xfer ? w_sel_d : 8'h00;
    assign bus.link_d_vld  = w_vld;
    assign bus.link_sof    = w_xfer & (r_byte_cnt == '0);
    assign bus.link_eof    = w_last | w_timeout;
    assign bus.grant_idx   = r_grant;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.timeout_err = w_timeout;

endmodule

// File: tb/tb_hsi_tx_sched.sv
// Bench for hsi_tx_sched: per-cycle behavioural model plus directed scenarios.
module tb_hsi_tx_sched;
    import hsi_sched_pkg::*;

    localparam int N_SRC       = 2;
    localparam int DP_LEN      = 4;
    localparam int GAP_LEN     = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int DW          = 8 * N_SRC;
`ifdef HSI_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int PH_IDLE = 0, PH_ARB = 1, PH_XFER = 2, PH_GAP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hsi_tx_sched_if #(.N_SRC(N_SRC)) bus ();

    hsi_tx_sched #(
        .N_SRC(N_SRC), .DP_LEN(DP_LEN), .GAP_LEN(GAP_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic bit bit_of(input logic [N_SRC-1:0] v, input int i);
        return |(v & (N_SRC'(1) << i));
    endfunction

    // Source byte sequencers: byte k of source i is {i, k}; restart whenever tx_en is low.
    int               seq [N_SRC];
    logic [N_SRC-1:0] last_ack = '0;

    task automatic cyc();
        logic [DW-1:0] v;
        @(posedge clk);
        #1;
        v = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (bit_of(last_ack, i)) seq[i]++;
            if (!bit_of(bus.src_tx_en, i)) seq[i] = 0;
            v |= DW'(8'(i * 16 + seq[i])) << (8 * i);
        end
        bus.src_d = v;
    endtask

    // Event log filled by the compare process
    int         q_sof[$], q_eof[$], q_to[$], q_xs[$], q_len[$], q_grant[$];
    logic [7:0] q_sof_d[$], q_eof_d[$];
    int         pkt_bytes = 0;
    logic [N_SRC-1:0] prev_txen = '0;

    task automatic clear_log();
        q_sof.delete(); q_eof.delete(); q_to.delete(); q_xs.delete();
        q_len.delete(); q_grant.delete(); q_sof_d.delete(); q_eof_d.delete();
    endtask

    function automatic int ev_cnt(input int kind);
        case (kind)
            0:       return q_sof.size();
            1:       return q_eof.size();
            2:       return q_to.size();
            default: return q_xs.size();
        endcase
    endfunction

    task automatic wait_ev(input int kind, input int n, input string nm);
        int b = 0;
        while (ev_cnt(kind) < n && b < 300) begin cyc(); b++; end
        chk(nm, 32'(ev_cnt(kind) >= n), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int b = 0;
        while (bus.busy && b < 100) begin cyc(); b++; end
        chk(nm, 32'(bus.busy), 32'd0);
    endtask

    // Behavioural model of the scheduler
    int               m_phase = PH_IDLE;
    int               m_rr    = N_SRC - 1;
    int               m_grant = 0;
    int               m_owner = 0;
    int               m_sent  = 0;
    int               m_stall = 0;
    int               m_gap   = 0;
    logic [N_SRC-1:0] e_oh, e_ack;
    logic             e_vld, e_sof, e_eof, e_to, sel_rdy, ok, found;
    logic [7:0]       e_d;
    int               pick;

    always @(negedge clk) begin
        e_oh = '0; e_ack = '0; e_vld = 1'b0; e_sof = 1'b0; e_eof = 1'b0;
        e_to = 1'b0; e_d = '0; ok = 1'b0; sel_rdy = 1'b0;
        if (m_phase == PH_XFER) begin
            e_oh    = N_SRC'(1) << m_owner;
            sel_rdy = |(bus.src_d_rdy & e_oh);
            ok      = sel_rdy & bus.link_rdy;
            e_to    = TO_EN && !ok && (m_stall == TIMEOUT_CYC - 1);
            e_vld   = sel_rdy && !e_to;
            e_d     = 8'(bus.src_d >> (8 * m_owner));
            e_ack   = (e_vld && bus.link_rdy) ? e_oh : '0;
            e_sof   = (e_ack != '0) && (m_sent == 0);
            e_eof   = ((e_ack != '0) && (m_sent == DP_LEN - 1)) || e_to;
            chk("link_d", 32'(bus.link_d), 32'(e_d));
        end
        chk("busy",        32'(bus.busy),        32'(m_phase != PH_IDLE));
        chk("grant_idx",   32'(bus.grant_idx),   32'(m_grant));
        chk("src_tx_en",   32'(bus.src_tx_en),   32'(e_oh));
        chk("link_d_vld",  32'(bus.link_d_vld),  32'(e_vld));
        chk("src_d_ack",   32'(bus.src_d_ack),   32'(e_ack));
        chk("link_sof",    32'(bus.link_sof),    32'(e_sof));
        chk("link_eof",    32'(bus.link_eof),    32'(e_eof));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e_to));

        last_ack = bus.src_d_ack;
        if (bus.src_d_ack != '0) begin
            if (bus.link_sof) begin
                q_sof.push_back(cyc_n); q_sof_d.push_back(bus.link_d);
                q_grant.push_back(int'(bus.grant_idx)); pkt_bytes = 0;
            end
            pkt_bytes++;
            if (bus.link_eof) begin
                q_eof.push_back(cyc_n); q_eof_d.push_back(bus.link_d); q_len.push_back(pkt_bytes);
            end
        end
        if (bus.timeout_err) q_to.push_back(cyc_n);
        if (bus.src_tx_en != '0 && prev_txen == '0) q_xs.push_back(cyc_n);
        prev_txen = bus.src_tx_en;

        if (rst) begin
            m_phase = PH_IDLE; m_rr = N_SRC - 1; m_grant = 0; pkt_bytes = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (bus.src_tx_rdy != '0) m_phase = PH_ARB;
                PH_ARB: begin
                    found = 1'b0; pick = 0;
                    for (int k = 1; k <= N_SRC; k++) begin
                        if (!found && bit_of(bus.src_tx_rdy, (m_rr + k) % N_SRC)) begin
                            found = 1'b1; pick = (m_rr + k) % N_SRC;
                        end
                    end
                    if (found) begin
                        m_owner = pick; m_rr = pick; m_grant = pick;
                        m_sent = 0; m_stall = 0; m_phase = PH_XFER;
                    end else begin
                        m_phase = PH_IDLE;
                    end
                end
                PH_XFER: begin
                    if (ok) begin
                        m_sent++; m_stall = 0;
                        if (m_sent == DP_LEN) begin m_phase = PH_GAP; m_gap = GAP_LEN; end
                    end else if (e_to) begin
                        m_phase = PH_GAP; m_gap = GAP_LEN;
                    end else begin
                        m_stall++;
                    end
                end
                default: begin
                    m_gap--;
                    if (m_gap == 0) m_phase = (bus.src_tx_rdy != '0) ? PH_ARB : PH_IDLE;
                end
            endcase
        end
        cyc_n++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N_SRC; i++) seq[i] = 0;
        bus.src_tx_rdy = '0; bus.src_d = '0; bus.src_d_rdy = '0; bus.link_rdy = 1'b0;
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_txen",  32'(bus.src_tx_en), 32'd0);
        chk("rst_grant", 32'(bus.grant_idx), 32'd0);
        rst = 1'b0;

        // 1: lone requester, two back-to-back packets
        bus.link_rdy = 1'b1; bus.src_d_rdy = '1; bus.src_tx_rdy = 2'b01;
        wait_ev(1, 2, "t1_wait_eof");
        chk("t1_grant0",   32'(q_grant[0]), 32'd0);
        chk("t1_grant1",   32'(q_grant[1]), 32'd0);
        chk("t1_len",      32'(q_len[0]),   32'd4);
        chk("t1_sof_d",    32'(q_sof_d[0]), 32'h00);
        chk("t1_eof_d",    32'(q_eof_d[0]), 32'h03);
        chk("t1_pkt_span", 32'(q_eof[0] - q_sof[0]), 32'd3);
        chk("t1_regrant",  32'(q_sof[1] - q_eof[0]), 32'd6);
        bus.src_tx_rdy = '0;
        wait_idle("t1_idle");

        // 2: both requesting, strict rotation from reset
        rst = 1'b1; cyc(); cyc(); rst = 1'b0; clear_log();
        bus.src_tx_rdy = 2'b11;
        wait_ev(1, 3, "t2_wait_eof");
        bus.src_tx_rdy = '0;
        chk("t2_grant0", 32'(q_grant[0]), 32'd0);
        chk("t2_grant1", 32'(q_grant[1]), 32'd1);
        chk("t2_grant2", 32'(q_grant[2]), 32'd0);
        chk("t2_src1_sof_d", 32'(q_sof_d[1]), 32'h10);
        chk("t2_src1_eof_d", 32'(q_eof_d[1]), 32'h13);
        wait_idle("t2_idle");

        // 3: link stall mid-packet
        clear_log(); bus.src_tx_rdy = 2'b01;
        wait_ev(0, 1, "t3_wait_sof");
        bus.link_rdy = 1'b0;
        repeat (5) begin
            #1;
            chk("t3_hold_d",   32'(bus.link_d),     32'h01);
            chk("t3_hold_vld", 32'(bus.link_d_vld), 32'd1);
            chk("t3_hold_ack", 32'(bus.src_d_ack),  32'd0);
            cyc();
        end
        bus.link_rdy = 1'b1; bus.src_tx_rdy = '0;
        wait_ev(1, 1, "t3_wait_eof");
        chk("t3_len",  32'(q_len[0]), 32'd4);
        chk("t3_span", 32'(q_eof[0] - q_sof[0]), 32'd8);
        wait_idle("t3_idle");

        // 4: reset pulse on byte 2
        clear_log(); bus.src_tx_rdy = 2'b01;
        wait_ev(0, 1, "t4_wait_sof");
        rst = 1'b1; cyc(); rst = 1'b0; clear_log();
        chk("t4_txen",  32'(bus.src_tx_en),  32'd0);
        chk("t4_vld",   32'(bus.link_d_vld), 32'd0);
        chk("t4_busy",  32'(bus.busy),       32'd0);
        chk("t4_grant", 32'(bus.grant_idx),  32'd0);
        chk("t4_eof",   32'(bus.link_eof),   32'd0);
        wait_ev(0, 1, "t4_wait_sof2");
        bus.src_tx_rdy = '0;
        chk("t4_restart_d", 32'(q_sof_d[0]), 32'h00);
        wait_ev(1, 1, "t4_wait_eof");
        chk("t4_len", 32'(q_len[0]), 32'd4);
        wait_idle("t4_idle");

        // 5: request withdrawn after sof
        clear_log(); bus.src_tx_rdy = 2'b01;
        wait_ev(0, 1, "t5_wait_sof");
        bus.src_tx_rdy = '0;
        wait_ev(1, 1, "t5_wait_eof");
        chk("t5_len", 32'(q_len[0]), 32'd4);
        wait_idle("t5_idle");
        repeat (10) cyc();
        chk("t5_no_more", 32'(q_sof.size()), 32'd1);
        chk("t5_busy",    32'(bus.busy),     32'd0);

`ifdef HSI_SCHED_TIMEOUT_EN
        // 6: source byte stream stuck, packet aborted, next source granted
        rst = 1'b1; cyc(); rst = 1'b0; clear_log();
        bus.src_d_rdy = '0; bus.src_tx_rdy = 2'b11;
        wait_ev(2, 1, "t6_wait_to");
        chk("t6_to_cycle", 32'(q_to[0] - q_xs[0]), 32'd7);
        bus.src_d_rdy = '1;
        wait_ev(0, 1, "t6_wait_sof");
        bus.src_tx_rdy = '0;
        chk("t6_next_grant", 32'(q_grant[0]), 32'd1);
        wait_idle("t6_idle");
`else
        // 6: source byte stream stalled, transfer waits without limit
        clear_log(); bus.src_d_rdy = '0; bus.src_tx_rdy = 2'b01;
        wait_ev(3, 1, "t6_wait_xfer");
        repeat (12) cyc();
        chk("t6_txen",   32'(bus.src_tx_en),   32'd1);
        chk("t6_busy",   32'(bus.busy),        32'd1);
        chk("t6_no_to",  32'(bus.timeout_err), 32'd0);
        bus.src_d_rdy = '1; bus.src_tx_rdy = '0;
        wait_ev(1, 1, "t6_wait_eof");
        chk("t6_len", 32'(q_len[0]), 32'd4);
        wait_idle("t6_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
